// File: rtl/ysyx_25040101_wb_arb_pkg.sv
// Shared constants and types for the write-back arbiter and its round-robin picker.
package ysyx_25040101_wb_arb_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;
  localparam int XLEN_DEF      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/ysyx_25040101_wb_rr_sel.sv
// Rotating-priority picker: the requester at index ptr has highest priority, then ptr+1, wrapping.
// Tie ptr to zero to get plain lowest-index-wins priority.
module ysyx_25040101_wb_rr_sel #(
  parameter int NUM   = 3,
  parameter int PTR_W = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [NUM-1:0]   valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM-1:0]   grant
);

  int best;
  int pos;

  // pos is each requester's distance from ptr; the closest valid one wins.
  always_comb begin
    grant = '0;
    best  = NUM;
    pos   = 0;
    for (int i = 0; i < NUM; i++) begin
      pos = (i + NUM - int'(ptr)) % NUM;
      if (valid[i] && (pos < best)) begin
        best     = pos;
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_25040101_wb_arb.sv
// Write-back arbiter feeding the single regfile write port, plus the RAW scoreboard for issue.
// Define YSYX_25040101_WB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module ysyx_25040101_wb_arb
  import ysyx_25040101_wb_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic                         iss_valid_i,
  input  logic [REG_ADDR_W-1:0]        iss_rd_i,
  input  logic                         flush_i,
  input  logic [REG_ADDR_W-1:0]        rs1_addr_i,
  input  logic [REG_ADDR_W-1:0]        rs2_addr_i,
  output logic                         rs1_busy_o,
  output logic                         rs2_busy_o,
  output logic [NUM_ARCH_REGS-1:0]     busy_o,
  output logic                         rd_wen_o,
  output logic [REG_ADDR_W-1:0]        rd_addr_o,
  output logic [XLEN-1:0]              rd_data_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         ptr;
  reg_addr_t                gnt_addr;
  logic [XLEN-1:0]          gnt_data;
  logic [NUM_ARCH_REGS-1:0] busy;

`ifdef YSYX_25040101_WB_RR_EN
  logic [PTR_W-1:0] gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  ysyx_25040101_wb_rr_sel #(
    .NUM   (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_sel (
    .valid (req_valid_i),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready_o = grant;

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_addr = req_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
        gnt_data = req_data_i[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are accepted but never reach the regfile.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wen_o  <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      rd_wen_o <= 1'b0;
      if (|grant) begin
        rd_wen_o  <= (gnt_addr != '0);
        rd_addr_o <= gnt_addr;
        rd_data_o <= gnt_data;
      end
    end
  end

  // Set after clear so an issue to the register being committed keeps it pending.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      busy <= '0;
    end else begin
      if (rd_wen_o) busy[rd_addr_o] <= 1'b0;
      if (iss_valid_i && (iss_rd_i != '0)) busy[iss_rd_i] <= 1'b1;
    end
  end

  assign busy_o     = busy;
  assign rs1_busy_o = busy[rs1_addr_i];
  assign rs2_busy_o = busy[rs2_addr_i];

endmodule

// File: tb/tb_ysyx_25040101_wb_arb.sv
// Bench for the write-back arbiter: directed vector table, random traffic against a reference model.
module tb_ysyx_25040101_wb_arb;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid_i;
  logic [14:0] req_addr_i;
  logic [95:0] req_data_i;
  logic [2:0]  req_ready_o;
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic        flush_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic [31:0] busy_o;
  logic        rd_wen_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  always #5 clk = ~clk;

  ysyx_25040101_wb_arb #(.NUM_REQ(N), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .flush_i     (flush_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_busy_o  (rs1_busy_o),
    .rs2_busy_o  (rs2_busy_o),
    .busy_o      (busy_o),
    .rd_wen_o    (rd_wen_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending-register set, last write presented, priority pointer.
  bit [31:0] m_busy;
  bit        m_wen;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  int        m_ptr;
  int        m_g;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [4:0]  rs1;
    logic [2:0]  e_ready;
    logic        e_rs1;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] v, input int p);
    int idx;
`ifndef YSYX_25040101_WB_RR_EN
    p = 0;
`endif
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_wen = 0; m_addr = '0; m_data = '0; m_ptr = 0; m_g = -1;
  endtask

  task automatic pre_model();
    logic [31:0] er;
    m_g = pick(req_valid_i, m_ptr);
    er  = (m_g >= 0) ? (32'd1 << m_g) : 32'd0;
    chk("m_ready", 32'(req_ready_o), er);
    chk("m_rs1_busy", 32'(rs1_busy_o), 32'(m_busy[rs1_addr_i]));
    chk("m_rs2_busy", 32'(rs2_busy_o), 32'(m_busy[rs2_addr_i]));
  endtask

  // Called right after the posedge, with the inputs that were sampled there.
  task automatic model_edge();
    bit [4:0] a;
    if (flush_i) m_busy = '0;
    else begin
      if (m_wen) m_busy[m_addr] = 1'b0;
      if (iss_valid_i && iss_rd_i != 0) m_busy[iss_rd_i] = 1'b1;
    end
    if (m_g >= 0) begin
      a      = req_addr_i[m_g*5 +: 5];
      m_wen  = (a != 0);
      m_addr = a;
      m_data = req_data_i[m_g*32 +: 32];
      m_ptr  = (m_g + 1) % N;
    end else begin
      m_wen = 0;
    end
  endtask

  task automatic post_model();
    chk("m_rd_wen", 32'(rd_wen_o), 32'(m_wen));
    chk("m_rd_addr", 32'(rd_addr_o), 32'(m_addr));
    chk("m_rd_data", rd_data_o, m_data);
    chk("m_busy", busy_o, m_busy);
  endtask

  function automatic vec_t mk(input logic [2:0] valid, input logic [14:0] addr, input logic [95:0] data,
                              input logic iss, input logic [4:0] iss_rd, input logic flush, input logic [4:0] rs1,
                              input logic [2:0] e_ready, input logic e_rs1, input logic e_wen,
                              input logic [4:0] e_addr, input logic [31:0] e_data, input logic [31:0] e_busy);
    vec_t v;
    v.valid = valid; v.addr = addr; v.data = data; v.iss = iss; v.iss_rd = iss_rd; v.flush = flush;
    v.rs1 = rs1; v.e_ready = e_ready; v.e_rs1 = e_rs1; v.e_wen = e_wen; v.e_addr = e_addr;
    v.e_data = e_data; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                       input logic iss, input logic [4:0] rd, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2);
    req_valid_i = v; req_addr_i = a; req_data_i = d;
    iss_valid_i = iss; iss_rd_i = rd; flush_i = fl; rs1_addr_i = r1; rs2_addr_i = r2;
  endtask

  logic [2:0]  cur_v;
  logic [14:0] cur_a;
  logic [95:0] cur_d;
  int          g;
  logic [4:0]  hold_a;
  logic [31:0] hold_d;

  initial begin
    // Directed vectors; expected values derived by hand from the write-back rules.
    vq.push_back(mk(3'b001, 15'd5, 96'hDEADBEEF, 0, 0, 0, 0, 3'b001, 0, 1, 5, 32'hDEADBEEF, 0));
    vq.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 5, 32'hDEADBEEF, 0));
    vq.push_back(mk(3'b100, 15'd0, {32'h1234, 64'h0}, 0, 0, 0, 0, 3'b100, 0, 0, 0, 32'h1234, 0));
    for (int k = 0; k < 6; k++) begin
`ifdef YSYX_25040101_WB_RR_EN
      g = k % 3;
`else
      g = 0;
`endif
      vq.push_back(mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 0, 0, 0, 0,
                      3'(1 << g), 0, 1, 5'(g + 1), 32'h11 * (g + 1), 0));
    end
`ifdef YSYX_25040101_WB_RR_EN
    hold_a = 5'd3; hold_d = 32'h33;
`else
    hold_a = 5'd1; hold_d = 32'h11;
`endif
    vq.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, hold_a, hold_d, 0));
    vq.push_back(mk(3'b000, 0, 0, 1, 7, 0, 7, 3'b000, 0, 0, hold_a, hold_d, 32'h80));
    vq.push_back(mk(3'b000, 0, 0, 0, 0, 0, 7, 3'b000, 1, 0, hold_a, hold_d, 32'h80));
    vq.push_back(mk(3'b001, 15'd7, 96'h77, 0, 0, 0, 7, 3'b001, 1, 1, 7, 32'h77, 32'h80));
    vq.push_back(mk(3'b000, 0, 0, 0, 0, 0, 7, 3'b000, 1, 0, 7, 32'h77, 0));
    vq.push_back(mk(3'b000, 0, 0, 0, 0, 0, 7, 3'b000, 0, 0, 7, 32'h77, 0));
    vq.push_back(mk(3'b001, 15'd9, 96'h99, 0, 0, 0, 0, 3'b001, 0, 1, 9, 32'h99, 0));
    vq.push_back(mk(3'b000, 0, 0, 1, 9, 0, 9, 3'b000, 0, 0, 9, 32'h99, 32'h200));
    vq.push_back(mk(3'b000, 0, 0, 0, 0, 0, 9, 3'b000, 1, 0, 9, 32'h99, 32'h200));
    vq.push_back(mk(3'b000, 0, 0, 1, 3, 0, 0, 3'b000, 0, 0, 9, 32'h99, 32'h208));
    vq.push_back(mk(3'b000, 0, 0, 1, 4, 0, 0, 3'b000, 0, 0, 9, 32'h99, 32'h218));
    vq.push_back(mk(3'b001, 15'd3, 96'h3333, 1, 10, 0, 10, 3'b001, 0, 1, 3, 32'h3333, 32'h618));
    vq.push_back(mk(3'b001, 15'd12, 96'hC, 1, 5, 1, 10, 3'b001, 1, 1, 12, 32'hC, 0));
    vq.push_back(mk(3'b000, 0, 0, 0, 0, 0, 12, 3'b000, 0, 0, 12, 32'hC, 0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_wen", 32'(rd_wen_o), 0);
    chk("rst_rd_addr", 32'(rd_addr_o), 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    rst = 1'b0;

    foreach (vq[r]) begin
      drive(vq[r].valid, vq[r].addr, vq[r].data, vq[r].iss, vq[r].iss_rd, vq[r].flush, vq[r].rs1, 0);
      #1;
      chk($sformatf("tbl%0d_ready", r), 32'(req_ready_o), 32'(vq[r].e_ready));
      chk($sformatf("tbl%0d_rs1", r), 32'(rs1_busy_o), 32'(vq[r].e_rs1));
      pre_model();
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d_wen", r), 32'(rd_wen_o), 32'(vq[r].e_wen));
      chk($sformatf("tbl%0d_addr", r), 32'(rd_addr_o), 32'(vq[r].e_addr));
      chk($sformatf("tbl%0d_data", r), rd_data_o, vq[r].e_data);
      chk($sformatf("tbl%0d_busy", r), busy_o, vq[r].e_busy);
      post_model();
      @(negedge clk);
    end

    // Random traffic; an unaccepted requester keeps its valid and payload.
    cur_v = '0; cur_a = '0; cur_d = '0; m_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!cur_v[i] || m_g == i) begin
          cur_v[i] = ($urandom_range(0, 9) < 6);
          cur_a[i*5 +: 5] = 5'($urandom_range(0, 31));
          cur_d[i*32 +: 32] = $urandom;
        end
      end
      drive(cur_v, cur_a, cur_d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #1;
      pre_model();
      @(posedge clk);
      model_edge();
      #1;
      post_model();
      @(negedge clk);
    end

    // Reset while a write sits in the output stage: the write is lost.
    drive(3'b001, 15'd6, 96'h6666, 1, 6, 0, 6, 0);
    #1;
    pre_model();
    @(posedge clk);
    model_edge();
    #1;
    post_model();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rd_wen", 32'(rd_wen_o), 0);
    chk("midrst_rd_addr", 32'(rd_addr_o), 0);
    chk("midrst_rd_data", rd_data_o, 0);
    chk("midrst_busy", busy_o, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_25040101_wb_arb.md
Name: ysyx_25040101_wb_arb

Overview:
- Write-back arbiter and scoreboard for the single-write-port register file.
- Shares the one rd write port between NUM_REQ producers (ALU, LSU, CSR unit) through a valid/ready handshake and drives the regfile rd_wen/rd_addr/rd_data inputs from a registered stage.
- Tracks per-register pending writes so the issue stage can stall on RAW hazards for rs1/rs2.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8); index 0 is ALU.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid_i  in  NUM_REQ  requester i has a write-back pending.
- req_addr_i  in  NUM_REQ*5  destination register, requester i at bits [5i+4:5i].
- req_data_i  in  NUM_REQ*XLEN  write data, requester i at slice i.
- req_ready_o  out  NUM_REQ  one-hot grant; transfer when valid&&ready.
- iss_valid_i  in  1  an instruction writing rd is issued this cycle.
- iss_rd_i  in  5  its destination register.
- flush_i  in  1  pipeline flush; clear scoreboard.
- rs1_addr_i  in  5  issue-stage source 1.
- rs2_addr_i  in  5  issue-stage source 2.
- rs1_busy_o  out  1  rs1 has a pending write.
- rs2_busy_o  out  1  rs2 has a pending write.
- busy_o  out  32  scoreboard vector; bit 0 is always 0.
- rd_wen_o  out  1  to regfile write enable.
- rd_addr_o  out  5  to regfile rd address.
- rd_data_o  out  XLEN  to regfile rd data.

Behaviour:
- Reset: rd_wen_o=0, rd_addr_o=0, rd_data_o=0, busy_o=0, round-robin pointer=0. req_ready_o is combinational and all 0 while no valid is asserted.
- Grant: combinational, at most one ready bit set, only to a valid requester. The output stage always accepts, so the block produces no backpressure beyond arbitration loss.
- A granted transfer is captured at the next posedge: rd_wen_o=(addr!=0), rd_addr_o=addr, rd_data_o=data. Latency is 1 cycle, and the output is held for exactly one cycle.
- With no grant, rd_wen_o=0 next cycle; rd_addr_o and rd_data_o hold their previous values.
- A request with addr 0 is accepted (ready=1) and dropped; rd_wen_o stays 0.
- Requesters hold valid, addr and data stable until accepted. An unaccepted requester must not change its payload.
- Scoreboard set: at a posedge with iss_valid_i and iss_rd_i!=0, busy[iss_rd_i]<=1.
- Scoreboard clear: at a posedge with rd_wen_o=1, busy[rd_addr_o]<=0. This is the edge at which the regfile commits.
- Set and clear of the same register on the same edge: set wins, and the bit stays 1.
- rs1_busy_o=busy[rs1_addr_i] and rs2_busy_o=busy[rs2_addr_i], both combinational. Address 0 always reads 0.
- flush_i: busy<=0 at the edge. flush_i overrides a simultaneous set.
- flush_i does not cancel the registered write already in the output stage or a grant made this cycle; both still reach the regfile.
- rst mid-transfer: the output stage is cleared and the captured write is lost. This is acceptable because the whole core resets.

Optional Feature:
- YSYX_25040101_WB_RR_EN defined: round-robin arbitration.
  - The pointer holds the index of the highest-priority requester.
  - After a grant to index g, the pointer moves to (g+1) mod NUM_REQ.
  - The pointer is unchanged when there is no grant.
- YSYX_25040101_WB_RR_EN undefined: fixed priority, lowest index wins. No pointer register exists.

Decomposition:
- Shared package constants: REG_ADDR_W=5, NUM_ARCH_REGS=32, XLEN default.
- Sub-module ysyx_25040101_wb_rr_sel: a parameterised round-robin/priority picker taking valid vector and pointer and returning a one-hot grant. It is reused later by the memory-bus arbiter.
- The scoreboard stays inline.

Test Plan:
- After reset, drive req0 valid with addr=5, data=0xDEADBEEF. Expect ready0=1 the same cycle, then rd_wen_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF next cycle, then rd_wen_o=0.
- Drive all three requesters valid for 6 cycles with addrs 1/2/3.
  - RR build: grants 0,1,2,0,1,2.
  - Fixed build: grant 0 every cycle, and req1/req2 ready stay 0.
- Request addr=0 with data=0x1234. Expect ready=1, then rd_wen_o=0 and busy_o unchanged.
- Issue rd=7; busy_o[7]=1 and rs1_busy_o=1 with rs1_addr_i=7. Then write back addr=7: busy[7] clears on the edge after rd_wen_o=1.
- Same edge: rd_wen_o=1 with rd_addr_o=9 and iss_valid_i with iss_rd_i=9. Expect busy[9] to remain 1.
- Set busy on regs 3, 4, 10, then pulse flush_i while a write to reg 3 is in the output stage. Expect busy_o=0 and the write still presented, rd_wen_o=1 with addr 3.
